// File: rtl/led_seq.sv
// led_seq: memory-mapped LED pattern sequencer.
//
// Accepts a command byte (speed[7:6], mode[5:4], pattern[3:0]) on a one-cycle
// begin_flag strobe and drives four LEDs. Modes: static, blink, rotate-left and
// rotate-right. Patterns advance once per tick; the tick period is
// TICK_DIV << (2*speed) clock cycles.
//
// Optional feature macro: LED_SEQ_BLINK_EN. When undefined, blink mode behaves
// as static, the phase bit is not built and state_reg[6] reads 0.
//
// Ports:
//   clock      in   1  system clock
//   reset      in   1  synchronous active-high reset
//   in_data    in   8  command byte
//   begin_flag in   1  load strobe
//   out_data   out  4  LED drive (registered)
//   state_reg  out  8  {active, phase, mode[1:0], out_data[3:0]} (registered)

module led_seq #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       begin_flag,
  output logic [3:0] out_data,
  output logic [7:0] state_reg
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CNT_W-1:0] TickDivW = CNT_W'(TICK_DIV);

  state_e           r_state, w_state_d;
  logic [3:0]       r_pattern, w_pattern_d;
  logic [1:0]       r_mode, w_mode_d;
  logic [1:0]       r_speed, w_speed_d;
  logic [CNT_W-1:0] r_presc, w_presc_d;
  logic [CNT_W-1:0] w_period;
  logic             w_tick;
  logic [3:0]       w_out_d;
  logic [7:0]       w_status_d;

`ifdef LED_SEQ_BLINK_EN
  logic r_phase, w_phase_d;
`else
  logic w_phase_d;
  assign w_phase_d = 1'b0;
`endif

  assign w_period = TickDivW << {r_speed, 1'b0};
  assign w_tick   = (r_state == StRun) && (r_presc == (w_period - CNT_W'(1)));

  always_comb begin
    w_state_d   = r_state;
    w_pattern_d = r_pattern;
    w_mode_d    = r_mode;
    w_speed_d   = r_speed;
    w_presc_d   = r_presc;
`ifdef LED_SEQ_BLINK_EN
    w_phase_d   = r_phase;
`endif

    case (r_state)
      StIdle: w_presc_d = '0;
      StRun: begin
        if (w_tick) begin
          w_presc_d = '0;
          case (r_mode)
`ifdef LED_SEQ_BLINK_EN
            2'b01:   w_phase_d = ~r_phase;
`endif
            2'b10:   w_pattern_d = {r_pattern[2:0], r_pattern[3]};
            2'b11:   w_pattern_d = {r_pattern[0], r_pattern[3:1]};
            default: ;
          endcase
        end else begin
          w_presc_d = r_presc + CNT_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A load overrides any tick action in the same cycle.
    if (begin_flag) begin
      w_state_d   = StRun;
      w_pattern_d = in_data[3:0];
      w_mode_d    = in_data[5:4];
      w_speed_d   = in_data[7:6];
      w_presc_d   = '0;
`ifdef LED_SEQ_BLINK_EN
      w_phase_d   = 1'b0;
`endif
    end

    // Outputs are derived from next-state so a load is visible one cycle later.
    w_out_d    = ((w_mode_d == 2'b01) && w_phase_d) ? 4'b0000 : w_pattern_d;
    w_status_d = {(w_state_d == StRun), w_phase_d, w_mode_d, w_out_d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pattern <= '0;
      r_mode    <= '0;
      r_speed   <= '0;
      r_presc   <= '0;
      out_data  <= '0;
      state_reg <= '0;
`ifdef LED_SEQ_BLINK_EN
      r_phase   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_pattern <= w_pattern_d;
      r_mode    <= w_mode_d;
      r_speed   <= w_speed_d;
      r_presc   <= w_presc_d;
      out_data  <= w_out_d;
      state_reg <= w_status_d;
`ifdef LED_SEQ_BLINK_EN
      r_phase   <= w_phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_seq.sv
// Testbench for led_seq: directed scenarios plus randomized loads and resets,
// checked every cycle against a closed-form model (ticks elapsed since the
// last load determine rotation amount and blink phase).

module tb_led_seq;

  localparam int unsigned TickDiv = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       begin_flag;
  logic [3:0] out_data;
  logic [7:0] state_reg;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  bit         m_active    = 1'b0;
  int         m_load_edge = 0;
  logic [7:0] m_cmd       = 8'h00;

  always #5 clock = ~clock;

  led_seq #(
    .TICK_DIV(TickDiv),
    .CNT_W   (24)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .begin_flag(begin_flag),
    .out_data  (out_data),
    .state_reg (state_reg)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at edge %0d", tag, got, exp, edge_cnt);
    end
  endtask

  // Expected status byte from elapsed ticks since the last load.
  function automatic logic [7:0] model_status();
    int         j, p, k, r;
    logic [3:0] pat;
    logic [7:0] dbl;
    logic [7:0] tmp;
    logic       phase;
    logic [3:0] led;
    if (!m_active) return 8'h00;
    j     = edge_cnt - m_load_edge;
    p     = TickDiv << (2 * int'(m_cmd[7:6]));
    k     = j / p;
    r     = k % 4;
    pat   = m_cmd[3:0];
    dbl   = {pat, pat};
    phase = 1'b0;
    case (m_cmd[5:4])
      2'b10: begin
        tmp = dbl << r;
        pat = tmp[7:4];
      end
      2'b11: begin
        tmp = dbl << ((4 - r) % 4);
        pat = tmp[7:4];
      end
`ifdef LED_SEQ_BLINK_EN
      2'b01: phase = ((k % 2) == 1);
`endif
      default: ;
    endcase
    led = phase ? 4'b0000 : pat;
    return {1'b1, phase, m_cmd[5:4], led};
  endfunction

  task automatic step();
    logic [7:0] exp;
    @(posedge clock);
    edge_cnt++;
    if (reset) begin
      m_active = 1'b0;
    end else if (begin_flag) begin
      m_active    = 1'b1;
      m_load_edge = edge_cnt;
      m_cmd       = in_data;
    end
    #1;
    exp = model_status();
    check_eq("model_out", {4'h0, out_data}, {4'h0, exp[3:0]});
    check_eq("model_status", state_reg, exp);
  endtask

  task automatic load(input logic [7:0] cmd);
    in_data    = cmd;
    begin_flag = 1'b1;
    step();
    begin_flag = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    begin_flag = 1'b0;
    in_data    = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    repeat (100) step();
    check_eq("idle_status", state_reg, 8'h00);
    check_eq("idle_out", {4'h0, out_data}, 8'h00);

    load(8'h05);
    check_eq("static_load", state_reg, 8'h85);
    repeat (200) step();
    check_eq("static_hold", state_reg, 8'h85);

    load(8'h21);
    check_eq("rotl_n1", {4'h0, out_data}, 8'h01);
    repeat (4) step();
    check_eq("rotl_n5", {4'h0, out_data}, 8'h02);
    repeat (4) step();
    check_eq("rotl_n9", {4'h0, out_data}, 8'h04);
    repeat (4) step();
    check_eq("rotl_n13", {4'h0, out_data}, 8'h08);
    repeat (4) step();
    check_eq("rotl_n17", {4'h0, out_data}, 8'h01);

    load(8'h38);
    check_eq("rotr_n1", {4'h0, out_data}, 8'h08);
    repeat (4) step();
    check_eq("rotr_n5", {4'h0, out_data}, 8'h04);

    load(8'h1F);
    check_eq("blink_n1", {4'h0, out_data}, 8'h0F);
    repeat (4) step();
`ifdef LED_SEQ_BLINK_EN
    check_eq("blink_n5", {4'h0, out_data}, 8'h00);
    check_eq("blink_phase", {7'h0, state_reg[6]}, 8'h01);
`else
    check_eq("blink_n5", {4'h0, out_data}, 8'h0F);
    check_eq("blink_status", state_reg, 8'h9F);
`endif
    repeat (4) step();
    check_eq("blink_n9", {4'h0, out_data}, 8'h0F);

    load(8'h61);
    repeat (15) step();
    check_eq("slow_before_tick", {4'h0, out_data}, 8'h01);
    load(8'h02);  // lands on the tick cycle
    check_eq("load_on_tick", state_reg, 8'h82);
    repeat (40) step();
    check_eq("load_on_tick_hold", state_reg, 8'h82);

    load(8'h2F);
    repeat (9) step();
    check_eq("rot_all_ones", {4'h0, out_data}, 8'h0F);

    load(8'h21);
    repeat (6) step();
    reset      = 1'b1;
    begin_flag = 1'b1;
    in_data    = 8'h21;
    step();
    reset      = 1'b0;
    begin_flag = 1'b0;
    check_eq("reset_mid_run", state_reg, 8'h00);
    repeat (50) step();
    check_eq("reset_no_ticks", state_reg, 8'h00);

    for (int i = 0; i < 4000; i++) begin
      begin_flag = ($urandom_range(29, 0) == 0);
      in_data    = 8'($urandom);
      reset      = ($urandom_range(699, 0) == 0);
      step();
    end
    reset      = 1'b0;
    begin_flag = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
